instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the control decoder: holds the program counter (PC) and instruction register (IR).
- Fetches instruction words from instruction memory over a single-outstanding request/valid handshake, using a one-entry tagged prefetch buffer.
- Presents the IR's opcode and operand fields to the decoder and datapath.
- Obeys the decoder's `pc_wr`, `branch`, `ir_wr` and reset strobes; raises a stall when a requested instruction is not yet available.

---
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC and IR, plus a one-entry tagged prefetch buffer.
// Memory requests use a single-outstanding req/valid handshake.
module instruction_fetch_unit #(
  parameter int unsigned DATA_WIDTH        = 11,
  parameter int unsigned INSTRUCTION_WIDTH = 16
) (
  input  logic                                    clock_in,
  input  logic                                    reset_in,
  input  logic                                    pc_wr_in,
  input  logic                                    branch_in,
  input  logic                                    ir_wr_in,
  input  logic                                    pc_reset_in,
  input  logic                                    ir_reset_in,
  output logic                                    imem_req_out,
  output logic [DATA_WIDTH-1:0]                   imem_addr_out,
  input  logic [INSTRUCTION_WIDTH-1:0]            imem_data_in,
  input  logic                                    imem_valid_in,
  output logic [INSTRUCTION_WIDTH-DATA_WIDTH-1:0] op_code_out,
  output logic [DATA_WIDTH-1:0]                   operand_out,
  output logic [DATA_WIDTH-1:0]                   pc_out,
  output logic                                    fetch_busy_out
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                         state_q, state_d;
  logic [DATA_WIDTH-1:0]          pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0]   ir_q, ir_d;
  logic [INSTRUCTION_WIDTH-1:0]   buf_data_q, buf_data_d;
  logic [DATA_WIDTH-1:0]          buf_addr_q, buf_addr_d;
  logic                           buf_valid_q, buf_valid_d;
  logic [DATA_WIDTH-1:0]          req_addr_q, req_addr_d;

  logic                           req;
  logic [DATA_WIDTH-1:0]          addr;
  logic                           resp;
  logic                           buf_hit;
  logic                           mem_hit;
  logic                           hit;

  assign buf_hit = buf_valid_q && (buf_addr_q == pc_q);

  // Fetch FSM and buffer fill
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    buf_data_d  = buf_data_q;
    buf_addr_d  = buf_addr_q;
    buf_valid_d = buf_valid_q;
    req         = 1'b0;
    addr        = pc_q;
    unique case (state_q)
      StIdle: begin
        req  = !buf_hit;
        addr = pc_q;
        if (req && !imem_valid_in) begin
          req_addr_d = pc_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        req  = 1'b1;
        addr = req_addr_q;
        if (imem_valid_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A completed response is always buffered under the address it was issued for
    if (req && imem_valid_in) begin
      buf_data_d  = imem_data_in;
      buf_addr_d  = addr;
      buf_valid_d = 1'b1;
    end
  end

  assign resp    = req && imem_valid_in;
  assign mem_hit = resp && (addr == pc_q);
  assign hit     = buf_hit || mem_hit;

  // PC and IR next state
  always_comb begin
    pc_d = pc_q;
    if (pc_reset_in) begin
      pc_d = '0;
    end else if (pc_wr_in) begin
      pc_d = branch_in ? ir_q[DATA_WIDTH-1:0] : pc_q + DATA_WIDTH'(1);
    end

    ir_d = ir_q;
    if (ir_reset_in) begin
      ir_d = '0;
    end else if (ir_wr_in && hit) begin
      ir_d = mem_hit ? imem_data_in : buf_data_q;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= '0;
      buf_data_q  <= '0;
      buf_addr_q  <= '0;
      buf_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      buf_data_q  <= buf_data_d;
      buf_addr_q  <= buf_addr_d;
      buf_valid_q <= buf_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  // Request and stall are gated directly by reset so they drop asynchronously
  assign imem_req_out   = reset_in && req;
  assign imem_addr_out  = addr;
  assign fetch_busy_out = reset_in && ir_wr_in && !hit;
  assign op_code_out    = ir_q[INSTRUCTION_WIDTH-1:DATA_WIDTH];
  assign operand_out    = ir_q[DATA_WIDTH-1:0];
  assign pc_out         = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a latency-programmable memory model.
module tb_instruction_fetch_unit;

  logic        clock_in;
  logic        reset_in;
  logic        pc_wr_in;
  logic        branch_in;
  logic        ir_wr_in;
  logic        pc_reset_in;
  logic        ir_reset_in;
  logic        imem_req_out;
  logic [10:0] imem_addr_out;
  logic [15:0] imem_data_in;
  logic        imem_valid_in;
  logic [4:0]  op_code_out;
  logic [10:0] operand_out;
  logic [10:0] pc_out;
  logic        fetch_busy_out;

  int tests;
  int fails;
  int lat;
  int wait_cnt;
  logic [15:0] mem [0:2047];

  instruction_fetch_unit #(
    .DATA_WIDTH       (11),
    .INSTRUCTION_WIDTH(16)
  ) dut (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .pc_wr_in      (pc_wr_in),
    .branch_in     (branch_in),
    .ir_wr_in      (ir_wr_in),
    .pc_reset_in   (pc_reset_in),
    .ir_reset_in   (ir_reset_in),
    .imem_req_out  (imem_req_out),
    .imem_addr_out (imem_addr_out),
    .imem_data_in  (imem_data_in),
    .imem_valid_in (imem_valid_in),
    .op_code_out   (op_code_out),
    .operand_out   (operand_out),
    .pc_out        (pc_out),
    .fetch_busy_out(fetch_busy_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Memory answers after `lat` cycles of a held request; garbage data when not valid
  always @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) wait_cnt <= 0;
    else if (imem_req_out) wait_cnt <= imem_valid_in ? 0 : wait_cnt + 1;
  end
  assign imem_valid_in = imem_req_out && (wait_cnt >= lat);
  assign imem_data_in  = imem_valid_in ? mem[imem_addr_out] : 16'hDEAD;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    lat = 0;
    repeat (3) step();
    tests++;
    if (pc_out !== 11'h000) begin
      fails++; $display("FAIL rst_pc_in_reset: got %h want 000", pc_out);
    end
    reset_in = 1'b1;
    #2;
    tests++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 11'h000) begin
      fails++; $display("FAIL rst_first_req: req %b addr %h want 1 000", imem_req_out, imem_addr_out);
    end
    ir_wr_in = 1'b1; pc_wr_in = 1'b1;
    step();
    tests++;
    if (pc_out !== 11'h001 || op_code_out !== 5'h03) begin
      fails++; $display("FAIL rst_preload: pc %h op %h want 001 03", pc_out, op_code_out);
    end
    ir_wr_in = 1'b0; pc_wr_in = 1'b0; lat = 5;
    step();
    #2;
    tests++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 11'h001) begin
      fails++; $display("FAIL rst_in_wait: req %b addr %h want 1 001", imem_req_out, imem_addr_out);
    end
    ir_wr_in = 1'b1;
    #1; reset_in = 1'b0; #1;
    tests++;
    if (pc_out !== 11'h000 || op_code_out !== 5'h00 || operand_out !== 11'h000) begin
      fails++; $display("FAIL rst_async_regs: pc %h op %h opnd %h want 000 00 000",
                        pc_out, op_code_out, operand_out);
    end
    tests++;
    if (imem_req_out !== 1'b0 || fetch_busy_out !== 1'b0 || imem_addr_out !== 11'h000) begin
      fails++; $display("FAIL rst_async_outs: req %b busy %b addr %h want 0 0 000",
                        imem_req_out, fetch_busy_out, imem_addr_out);
    end
    ir_wr_in = 1'b0;
    step(); step();
    reset_in = 1'b1;
    #2;
    tests++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 11'h000) begin
      fails++; $display("FAIL rst_release: req %b addr %h want 1 000", imem_req_out, imem_addr_out);
    end
    lat = 0;
    step();
  endtask

  task automatic test_zero_wait();
    ir_wr_in = 1'b1;
    #2;
    tests++;
    if (fetch_busy_out !== 1'b0) begin
      fails++; $display("FAIL zw_busy1: got %b want 0", fetch_busy_out);
    end
    step();
    tests++;
    if (op_code_out !== 5'h03 || operand_out !== 11'h005 || pc_out !== 11'h000) begin
      fails++; $display("FAIL zw_ldi: op %h opnd %h pc %h want 03 005 000",
                        op_code_out, operand_out, pc_out);
    end
    ir_wr_in = 1'b0; pc_wr_in = 1'b1;
    step();
    tests++;
    if (pc_out !== 11'h001) begin
      fails++; $display("FAIL zw_pc1: got %h want 001", pc_out);
    end
    pc_wr_in = 1'b0; ir_wr_in = 1'b1;
    #2;
    tests++;
    if (fetch_busy_out !== 1'b0) begin
      fails++; $display("FAIL zw_busy2: got %b want 0", fetch_busy_out);
    end
    step();
    tests++;
    if (op_code_out !== 5'h04 || operand_out !== 11'h010) begin
      fails++; $display("FAIL zw_add: op %h opnd %h want 04 010", op_code_out, operand_out);
    end
    ir_wr_in = 1'b0; pc_wr_in = 1'b1;
    step();
    tests++;
    if (pc_out !== 11'h002) begin
      fails++; $display("FAIL zw_pc2: got %h want 002", pc_out);
    end
    pc_wr_in = 1'b0;
  endtask

  task automatic test_wait_states();
    int busy_cnt;
    bit addr_ok;
    bit early;
    bit done;
    busy_cnt = 0; addr_ok = 1'b1; early = 1'b0; done = 1'b0;
    lat = 0; pc_wr_in = 1'b1;
    step(); step();
    pc_wr_in = 1'b0; lat = 3; ir_wr_in = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      #2;
      if (imem_req_out !== 1'b1 || imem_addr_out !== 11'h004) addr_ok = 1'b0;
      if (fetch_busy_out === 1'b1) busy_cnt++;
      else done = 1'b1;
      @(posedge clock_in); #1;
      if (!done && operand_out !== 11'h010) early = 1'b1;
    end
    ir_wr_in = 1'b0; lat = 0;
    tests++;
    if (!done) begin
      fails++; $display("FAIL ws_timeout: busy still %b after 10 cycles want 0", fetch_busy_out);
    end
    tests++;
    if (busy_cnt != 3) begin
      fails++; $display("FAIL ws_busy_cycles: got %0d want 3", busy_cnt);
    end
    tests++;
    if (!addr_ok) begin
      fails++; $display("FAIL ws_addr_stable: got unstable want 004 held");
    end
    tests++;
    if (early) begin
      fails++; $display("FAIL ws_ir_early: IR changed before valid edge want unchanged");
    end
    tests++;
    if (op_code_out !== 5'h07 || operand_out !== 11'h2BC) begin
      fails++; $display("FAIL ws_ir_load: op %h opnd %h want 07 2bc", op_code_out, operand_out);
    end
  endtask

  task automatic test_branch();
    pc_wr_in = 1'b1;
    step();
    pc_wr_in = 1'b0; ir_wr_in = 1'b1;
    step();
    tests++;
    if (op_code_out !== 5'h0E || operand_out !== 11'h123) begin
      fails++; $display("FAIL br_jmp_ir: op %h opnd %h want 0e 123", op_code_out, operand_out);
    end
    ir_wr_in = 1'b0; pc_wr_in = 1'b1; branch_in = 1'b1;
    step();
    tests++;
    if (pc_out !== 11'h123) begin
      fails++; $display("FAIL br_pc: got %h want 123", pc_out);
    end
    pc_wr_in = 1'b0; branch_in = 1'b0; ir_wr_in = 1'b1;
    #2;
    tests++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 11'h123) begin
      fails++; $display("FAIL br_req: req %b addr %h want 1 123", imem_req_out, imem_addr_out);
    end
    step();
    tests++;
    if (op_code_out !== 5'h12 || operand_out !== 11'h005) begin
      fails++; $display("FAIL br_beq_ir: op %h opnd %h want 12 005", op_code_out, operand_out);
    end
    ir_wr_in = 1'b0; pc_wr_in = 1'b1;
    step();
    tests++;
    if (pc_out !== 11'h124) begin
      fails++; $display("FAIL br_not_taken: got %h want 124", pc_out);
    end
    pc_wr_in = 1'b0;
  endtask

  task automatic test_wrap_priority();
    ir_wr_in = 1'b1;
    step();
    ir_wr_in = 1'b0; pc_wr_in = 1'b1; branch_in = 1'b1;
    step();
    tests++;
    if (pc_out !== 11'h7FF) begin
      fails++; $display("FAIL wp_to_7ff: got %h want 7ff", pc_out);
    end
    branch_in = 1'b0;
    step();
    tests++;
    if (pc_out !== 11'h000) begin
      fails++; $display("FAIL wp_wrap: got %h want 000", pc_out);
    end
    step();
    pc_reset_in = 1'b1; branch_in = 1'b1;
    step();
    tests++;
    if (pc_out !== 11'h000) begin
      fails++; $display("FAIL wp_pc_reset_prio: got %h want 000", pc_out);
    end
    pc_reset_in = 1'b0; pc_wr_in = 1'b0; branch_in = 1'b0;
    ir_reset_in = 1'b1; ir_wr_in = 1'b1;
    #2;
    tests++;
    if (fetch_busy_out !== 1'b0) begin
      fails++; $display("FAIL wp_ir_hit: busy %b want 0", fetch_busy_out);
    end
    step();
    tests++;
    if (op_code_out !== 5'h00 || operand_out !== 11'h000) begin
      fails++; $display("FAIL wp_ir_reset_prio: op %h opnd %h want 00 000", op_code_out, operand_out);
    end
    ir_reset_in = 1'b0; ir_wr_in = 1'b0;
  endtask

  task automatic test_stale();
    bit held_ok;
    bit tag_ok;
    bit new_req_ok;
    bit saw_stale;
    bit done;
    int old_cycles;
    int phase;
    held_ok = 1'b1; tag_ok = 1'b0; new_req_ok = 1'b0; saw_stale = 1'b0; done = 1'b0;
    old_cycles = 0; phase = 0;
    lat = 0; pc_wr_in = 1'b1;
    step(); step();
    pc_wr_in = 1'b0; ir_wr_in = 1'b1;
    step();
    ir_wr_in = 1'b0; pc_wr_in = 1'b1; branch_in = 1'b1;
    step();
    pc_wr_in = 1'b0; branch_in = 1'b0; ir_wr_in = 1'b1;
    step();
    tests++;
    if (operand_out !== 11'h200) begin
      fails++; $display("FAIL st_setup_ir: got %h want 200", operand_out);
    end
    ir_wr_in = 1'b0; pc_wr_in = 1'b1; lat = 4;
    step();
    branch_in = 1'b1;
    #2;
    tests++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 11'h010) begin
      fails++; $display("FAIL st_first_req: req %b addr %h want 1 010", imem_req_out, imem_addr_out);
    end
    step();
    tests++;
    if (pc_out !== 11'h200) begin
      fails++; $display("FAIL st_jump: got %h want 200", pc_out);
    end
    pc_wr_in = 1'b0; branch_in = 1'b0; ir_wr_in = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #2;
      if (phase == 0) begin
        if (imem_req_out !== 1'b1 || imem_addr_out !== 11'h010 || fetch_busy_out !== 1'b1)
          held_ok = 1'b0;
        old_cycles++;
        if (imem_valid_in === 1'b1) phase = 1;
      end else begin
        if (phase == 2) new_req_ok = (imem_req_out === 1'b1) && (imem_addr_out === 11'h200);
        if (fetch_busy_out !== 1'b1) done = 1'b1;
        phase = 3;
      end
      @(posedge clock_in); #1;
      if (operand_out === 11'h2AA) saw_stale = 1'b1;
      if (phase == 1) begin
        tag_ok = (dut.buf_addr_q === 11'h010);
        phase = 2;
      end
    end
    ir_wr_in = 1'b0; lat = 0;
    tests++;
    if (!done) begin
      fails++; $display("FAIL st_timeout: busy %b after 20 cycles want 0", fetch_busy_out);
    end
    tests++;
    if (!held_ok || old_cycles != 4) begin
      fails++; $display("FAIL st_old_held: ok %b cycles %0d want 1 4", held_ok, old_cycles);
    end
    tests++;
    if (!tag_ok) begin
      fails++; $display("FAIL st_buf_tag: got %h want 010", dut.buf_addr_q);
    end
    tests++;
    if (!new_req_ok) begin
      fails++; $display("FAIL st_new_req: no request to 200 right after old completion want req 200");
    end
    tests++;
    if (saw_stale || op_code_out !== 5'h0A || operand_out !== 11'h200) begin
      fails++; $display("FAIL st_ir: stale %b op %h opnd %h want 0 0a 200",
                        saw_stale, op_code_out, operand_out);
    end
  endtask

  initial begin
    tests = 0; fails = 0; lat = 0;
    reset_in = 1'b0; pc_wr_in = 1'b0; branch_in = 1'b0; ir_wr_in = 1'b0;
    pc_reset_in = 1'b0; ir_reset_in = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[11'h000] = 16'h1805;
    mem[11'h001] = 16'h2010;
    mem[11'h002] = 16'h400F;
    mem[11'h004] = 16'h3ABC;
    mem[11'h005] = 16'h7123;
    mem[11'h00F] = 16'h4200;
    mem[11'h010] = 16'hAAAA;
    mem[11'h123] = 16'h9005;
    mem[11'h124] = 16'h07FF;
    mem[11'h200] = 16'h5200;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_wrap_priority();
    test_stale();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
